fpga_bram_dp: RTL and testbench
===============================

FPGA_BRAM_DP -- requirements
Module: fpga_bram_dp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 64, word width in bits; multiple of 8.
- ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from accepted access to output; legal values 1 or 2.
- WRITE_MODE, 0, same-port read-during-write; 0 = read-first, 1 = write-first.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning), with clk and rst first:
- clk, in, 1, the only clock; rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- ena, in, 1, port A access enable.
- wea, in, DATA_WIDTH/8, port A byte write enables; all-zero means read.
- addra, in, ADDR_WIDTH, port A word address.
- dina, in, DATA_WIDTH, port A write data.
- douta, out, DATA_WIDTH, port A read data.
- valida, out, 1, douta valid strobe.
- enb, in, 1, port B access enable.
- web, in, DATA_WIDTH/8, port B byte write enables.
- addrb, in, ADDR_WIDTH, port B word address.
- dinb, in, DATA_WIDTH, port B write data.
- doutb, out, DATA_WIDTH, port B read data.
- validb, out, 1, doutb valid strobe.
- error, out, 1, sticky collision flag.

Function
REQ-003 An access is accepted on a rising clk edge when its port enable is 1; ports SHALL be fully independent except as stated in REQ-008 and REQ-009.
REQ-004 On an accepted access, the port SHALL write byte lane i (bits 8i+7:8i) of the addressed word from din when its write enable bit i is 1, and SHALL leave all other lanes unchanged.
REQ-005 Every accepted access (read or write) SHALL produce exactly one valid pulse, one cycle wide, READ_LATENCY cycles after acceptance, with dout carrying that access's read data in the same cycle.
REQ-006 With READ_LATENCY=2, the block SHALL add an output register stage; back-to-back accesses SHALL sustain one result per cycle per port, in acceptance order.
REQ-007 Same-port read data on a write SHALL be the pre-write word when WRITE_MODE=0, and the post-write merged word when WRITE_MODE=1.
REQ-008 Cross-port write/read to the same address in the same cycle: the reading port SHALL return the pre-write word (read-first), in either WRITE_MODE.
REQ-009 Both ports writing the same address in the same cycle: for lanes enabled on both ports, port A data SHALL be stored; lanes enabled on only one port SHALL take that port's data.
REQ-010 When a port is not enabled, its dout SHALL hold its last value and its valid SHALL be 0 once in-flight results have drained.
REQ-011 Memory contents SHALL be undefined at power-up; no initialisation file is loaded by this block.
REQ-012 error, once set, SHALL remain 1 until rst.

Reset
REQ-013 While rst=1: douta=0, doutb=0, valida=0, validb=0, error=0, and all latency-pipeline stages SHALL be cleared immediately (asynchronously).
REQ-014 Memory contents SHALL NOT be altered by reset; accesses accepted in the cycle of, or in flight at, reset assertion SHALL produce no valid pulse. Any write accepted on the same edge that rst asserts SHALL be ignored.

Configuration
REQ-015 With macro FPGA_BRAM_COLLISION_CHECK_EN defined, error SHALL set on the cycle after any accepted same-address access pair in which at least one port writes and the ports' byte lanes overlap (write/write) or any write meets a cross-port read.
REQ-016 Without FPGA_BRAM_COLLISION_CHECK_EN, error SHALL be tied to 0, and REQ-008 and REQ-009 data behaviour SHALL be unchanged.

Verification
REQ-017 Latency: READ_LATENCY=1, write 0x1122334455667788 to address 0x010 via A, then read it via B → doutb=0x1122334455667788 with validb=1 exactly 1 cycle after the read. Repeat with READ_LATENCY=2 → 2 cycles.
REQ-018 Byte enables: preload address 0x020 with 0xFFFFFFFFFFFFFFFF, then write wea=0x0F with dina=0 → read returns 0xFFFFFFFF00000000.
REQ-019 Write mode: address 0x030 holds 0xA, then A writes 0xB with a full mask → douta=0xA when WRITE_MODE=0 and 0xB when WRITE_MODE=1.
REQ-020 Collision: A and B both write address 0x040 with full masks (A=0x1, B=0x2) → a later read returns 0x1. error=1 from the next cycle with the macro, and stays 0 without it. Then A writes address 0x050 while B reads 0x050 → B gets the old data.
REQ-021 Reset: issue 2-deep back-to-back reads with READ_LATENCY=2, assert rst mid-flight → no valid pulses, and all outputs=0 immediately. Memory data written before reset SHALL still read back after reset.

Source files
------------

// File: rtl/fpga_bram_dp.sv
// fpga_bram_dp: true dual-port byte-write block RAM, 1- or 2-cycle read latency.
// Define FPGA_BRAM_COLLISION_CHECK_EN to enable the sticky same-address collision flag.
module fpga_bram_dp #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  output logic                    valida,
  input  logic                    enb,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    validb,
  output logic                    error
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] din,
    input logic [NB-1:0]         we
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) r[8*i +: 8] = din[8*i +: 8];
    end
    return r;
  endfunction

  // Port A is applied last so it wins lanes both ports write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        if (enb && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        if (ena && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  logic                  va1;
  logic                  vb1;
  logic [DATA_WIDTH-1:0] qa1;
  logic [DATA_WIDTH-1:0] qb1;

  // Cross-port reads always see the pre-write array word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va1 <= 1'b0;
      vb1 <= 1'b0;
      qa1 <= '0;
      qb1 <= '0;
    end else begin
      va1 <= ena;
      vb1 <= enb;
      if (ena) begin
        qa1 <= (WRITE_MODE == 1) ? merge(mem[addra], dina, wea)
                                 : mem[addra];
      end
      if (enb) begin
        qb1 <= (WRITE_MODE == 1) ? merge(mem[addrb], dinb, web)
                                 : mem[addrb];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  va2;
      logic                  vb2;
      logic [DATA_WIDTH-1:0] qa2;
      logic [DATA_WIDTH-1:0] qb2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          va2 <= 1'b0;
          vb2 <= 1'b0;
          qa2 <= '0;
          qb2 <= '0;
        end else begin
          va2 <= va1;
          vb2 <= vb1;
          if (va1) qa2 <= qa1;
          if (vb1) qb2 <= qb1;
        end
      end

      assign douta  = qa2;
      assign valida = va2;
      assign doutb  = qb2;
      assign validb = vb2;
    end else begin : g_lat1
      assign douta  = qa1;
      assign valida = va1;
      assign doutb  = qb1;
      assign validb = vb1;
    end
  endgenerate

`ifdef FPGA_BRAM_COLLISION_CHECK_EN
  logic wr_a;
  logic wr_b;
  logic hit;
  logic err_q;

  assign wr_a = |wea;
  assign wr_b = |web;
  assign hit  = ena && enb && (addra == addrb) &&
                ((wr_a && wr_b) ? |(wea & web) : (wr_a || wr_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hit) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_bram_dp.sv
// tb_fpga_bram_dp: directed table, random traffic and reset checks for two
// build variants (latency 1 read-first, latency 2 write-first).
module tb_fpga_bram_dp;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NB = 8;

`ifdef FPGA_BRAM_COLLISION_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;

  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          valida0, validb0, valida1, validb1;
  logic          error0, error1;

  fpga_bram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_MODE(0)
  ) u_rl1 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb0), .validb(validb0),
    .error(error0)
  );

  fpga_bram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_MODE(1)
  ) u_rl2 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .valida(valida1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb1), .validb(validb1),
    .error(error1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    logic [NB-1:0] k;
  } ent_t;

  logic [DW-1:0] mdata  [int];
  logic [NB-1:0] mknown [int];
  ent_t          pq [4][$];
  logic [DW-1:0] last_d [4];
  logic [NB-1:0] last_k [4];
  bit            exp_v  [4];
  bit            exp_err;

  function automatic logic [DW-1:0] lmask(input logic [NB-1:0] k);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = {8{k[i]}};
    return r;
  endfunction

  function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o,
                                        input logic [DW-1:0] n,
                                        input logic [NB-1:0] we);
    return (o & ~lmask(we)) | (n & lmask(we));
  endfunction

  function automatic logic [DW-1:0] out_d(input int i);
    case (i)
      0: return douta0;
      1: return doutb0;
      2: return douta1;
      default: return doutb1;
    endcase
  endfunction

  function automatic logic out_v(input int i);
    case (i)
      0: return valida0;
      1: return validb0;
      2: return valida1;
      default: return validb1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp, input logic [DW-1:0] msk);
    checks++;
    if (((act ^ exp) & msk) !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, msk);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      last_d[i] = '0;
      last_k[i] = '1;
      exp_v[i]  = 1'b0;
    end
    exp_err = 1'b0;
  endtask

  // Called just after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit            en [2];
    logic [NB-1:0] we [2];
    logic [DW-1:0] din [2];
    int            ad [2];
    logic [DW-1:0] od [2];
    logic [NB-1:0] ok [2];
    ent_t          e;
    if (rst) begin
      model_reset();
      return;
    end
    en[0] = ena;  we[0] = wea;  din[0] = dina;  ad[0] = int'(addra);
    en[1] = enb;  we[1] = web;  din[1] = dinb;  ad[1] = int'(addrb);
    for (int p = 0; p < 2; p++) begin
      od[p] = mdata.exists(ad[p]) ? mdata[ad[p]] : '0;
      ok[p] = mknown.exists(ad[p]) ? mknown[ad[p]] : '0;
    end
    if (CC && en[0] && en[1] && ad[0] == ad[1] && (we[0] != 0 || we[1] != 0)) begin
      if (!(we[0] != 0 && we[1] != 0) || (we[0] & we[1]) != 0) exp_err = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        int i;
        i = d * 2 + p;
        e.v = en[p];
        if (d == 1 && we[p] != 0) begin
          e.d = mrg(od[p], din[p], we[p]);
          e.k = ok[p] | we[p];
        end else begin
          e.d = od[p];
          e.k = ok[p];
        end
        pq[i].push_back(e);
        if (pq[i].size() > d + 1) void'(pq[i].pop_front());
        exp_v[i] = 1'b0;
        if (pq[i].size() == d + 1 && pq[i][0].v) begin
          exp_v[i]  = 1'b1;
          last_d[i] = pq[i][0].d;
          last_k[i] = pq[i][0].k;
        end
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (en[p] && we[p] != 0) begin
        if (!mdata.exists(ad[p])) begin
          mdata[ad[p]]  = '0;
          mknown[ad[p]] = '0;
        end
        mdata[ad[p]]  = mrg(mdata[ad[p]], din[p], we[p]);
        mknown[ad[p]] = mknown[ad[p]] | we[p];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("valid dut%0d port%0d", i / 2, i % 2),
          {63'd0, out_v(i)}, {63'd0, exp_v[i]}, 64'd1);
      chk($sformatf("dout dut%0d port%0d", i / 2, i % 2),
          out_d(i), last_d[i], lmask(last_k[i]));
    end
    chk("error dut0", {63'd0, error0}, {63'd0, exp_err}, 64'd1);
    chk("error dut1", {63'd0, error1}, {63'd0, exp_err}, 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit ea, input logic [NB-1:0] wa, input int aa,
                       input logic [DW-1:0] da, input bit eb,
                       input logic [NB-1:0] wb, input int ab,
                       input logic [DW-1:0] db);
    ena = ea; wea = wa; addra = aa[AW-1:0]; dina = da;
    enb = eb; web = wb; addrb = ab[AW-1:0]; dinb = db;
  endtask

  task automatic idle();
    drive(1'b0, '0, 0, '0, 1'b0, '0, 0, '0);
  endtask

  typedef struct {
    bit            ea;
    logic [NB-1:0] wa;
    int            aa;
    logic [DW-1:0] da;
    bit            eb;
    logic [NB-1:0] wb;
    int            ab;
    logic [DW-1:0] db;
    bit            ca0;
    logic [DW-1:0] xa0;
    bit            ca1;
    logic [DW-1:0] xa1;
    bit            cb;
    logic [DW-1:0] xb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] keep;

    tbl[0]  = '{1, 8'hFF, 'h010, 64'h1122334455667788, 0, 8'h00, 0, 64'h0,
                0, 64'h0, 1, 64'h1122334455667788, 0, 64'h0};
    tbl[1]  = '{0, 8'h00, 0, 64'h0, 1, 8'h00, 'h010, 64'h0,
                0, 64'h0, 0, 64'h0, 1, 64'h1122334455667788};
    tbl[2]  = '{1, 8'hFF, 'h020, 64'hFFFFFFFFFFFFFFFF, 0, 8'h00, 0, 64'h0,
                0, 64'h0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0};
    tbl[3]  = '{1, 8'h0F, 'h020, 64'h0, 0, 8'h00, 0, 64'h0,
                1, 64'hFFFFFFFFFFFFFFFF, 1, 64'hFFFFFFFF00000000, 0, 64'h0};
    tbl[4]  = '{0, 8'h00, 0, 64'h0, 1, 8'h00, 'h020, 64'h0,
                0, 64'h0, 0, 64'h0, 1, 64'hFFFFFFFF00000000};
    tbl[5]  = '{1, 8'hFF, 'h030, 64'hA, 0, 8'h00, 0, 64'h0,
                0, 64'h0, 1, 64'hA, 0, 64'h0};
    tbl[6]  = '{1, 8'hFF, 'h030, 64'hB, 0, 8'h00, 0, 64'h0,
                1, 64'hA, 1, 64'hB, 0, 64'h0};
    tbl[7]  = '{1, 8'hFF, 'h040, 64'h1, 1, 8'hFF, 'h040, 64'h2,
                0, 64'h0, 1, 64'h1, 0, 64'h0};
    tbl[8]  = '{1, 8'h00, 'h040, 64'h0, 0, 8'h00, 0, 64'h0,
                1, 64'h1, 1, 64'h1, 0, 64'h0};
    tbl[9]  = '{1, 8'hFF, 'h050, 64'h5, 0, 8'h00, 0, 64'h0,
                0, 64'h0, 1, 64'h5, 0, 64'h0};
    tbl[10] = '{1, 8'hFF, 'h050, 64'h6, 1, 8'h00, 'h050, 64'h0,
                1, 64'h5, 1, 64'h6, 1, 64'h5};
    tbl[11] = '{0, 8'h00, 0, 64'h0, 1, 8'h00, 'h050, 64'h0,
                0, 64'h0, 0, 64'h0, 1, 64'h6};

    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step();

    // Directed vectors: latency-1 result after the first edge,
    // latency-2 result after the following idle edge.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da,
            tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      step();
      if (tbl[i].ca0) chk($sformatf("vec%0d douta rl1", i), douta0, tbl[i].xa0, '1);
      if (tbl[i].cb)  chk($sformatf("vec%0d doutb rl1", i), doutb0, tbl[i].xb, '1);
      chk($sformatf("vec%0d valida rl1", i), {63'd0, valida0}, {63'd0, tbl[i].ea}, 64'd1);
      idle();
      step();
      if (tbl[i].ca1) chk($sformatf("vec%0d douta rl2", i), douta1, tbl[i].xa1, '1);
      if (tbl[i].cb)  chk($sformatf("vec%0d doutb rl2", i), doutb1, tbl[i].xb, '1);
      chk($sformatf("vec%0d validb rl2", i), {63'd0, validb1}, {63'd0, tbl[i].eb}, 64'd1);
    end
    chk("collision flag rl1", {63'd0, error0}, {63'd0, CC}, 64'd1);
    chk("collision flag rl2", {63'd0, error1}, {63'd0, CC}, 64'd1);

    // Random traffic over a small preloaded window to force collisions.
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 8'hFF, 'h100 + a, {$urandom, $urandom}, 1'b0, '0, 0, '0);
      step();
    end
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 8'(($urandom)) : 8'h00,
            'h100 + $urandom_range(0, 7), {$urandom, $urandom},
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 8'(($urandom)) : 8'h00,
            'h100 + $urandom_range(0, 7), {$urandom, $urandom});
      step();
    end
    idle();
    repeat (3) step();

    // Reset with two reads in flight, plus a write held across a reset edge.
    keep = 64'hCAFEF00D12345678;
    drive(1'b1, 8'hFF, 'h060, keep, 1'b0, '0, 0, '0);
    step();
    idle();
    step();
    drive(1'b1, 8'h00, 'h060, '0, 1'b1, 8'h00, 'h060, '0);
    step();
    step();
    #2;
    rst = 1'b1;
    drive(1'b1, 8'hFF, 'h060, 64'hDEADBEEFDEADBEEF, 1'b0, '0, 0, '0);
    #1;
    model_reset();
    check_all();
    chk("reset douta rl2", douta1, '0, '1);
    chk("reset valida rl2", {63'd0, valida1}, 64'd0, 64'd1);
    step();
    #2;
    rst = 1'b0;
    idle();
    repeat (3) step();
    drive(1'b1, 8'h00, 'h060, '0, 1'b0, '0, 0, '0);
    step();
    chk("post-reset read rl1", douta0, keep, '1);
    idle();
    step();
    chk("post-reset read rl2", douta1, keep, '1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
